// File: rtl/prince_byte_loader.sv
// rtl/prince_byte_loader.sv - byte-serial frame loader and ciphertext streamer for the combinational PRINCE core
//
// Optional feature macro: KEY_CACHE_EN
//   defined   : load_key=0 on the first byte starts an 8-byte plaintext-only frame that reuses the cached k0/k1
//   undefined : load_key is ignored and every frame carries k0, k1 and plaintext (24 bytes)
module prince_byte_loader #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        load_key,
    output logic [63:0] core_pt,
    output logic [63:0] core_k0,
    output logic [63:0] core_k1,
    input  logic [63:0] core_ct,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K0,
        S_LOAD_K1,
        S_LOAD_PT,
        S_SETTLE,
        S_SEND
    } state_t;

    // Timer value on which the core output is considered settled.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  timer_q, timer_d;
    logic [63:0] k0_q, k0_d;
    logic [63:0] k1_q, k1_d;
    logic [63:0] pt_q, pt_d;
    logic [63:0] ct_q, ct_d;
    logic        in_ready_c;
    logic        out_valid_c;
    logic [5:0]  byte_lsb;

    // Byte i of a field lands in bits [63-8i -: 8], so the first byte is the MSB.
    assign byte_lsb = {3'd7 - cnt_q, 3'b000};

`ifndef KEY_CACHE_EN
    logic unused_load_key;
    assign unused_load_key = load_key;
`endif

    // State, counters and data registers; reset drops any partially loaded frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            timer_q <= 4'd0;
            k0_q    <= 64'd0;
            k1_q    <= 64'd0;
            pt_q    <= 64'd0;
            ct_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
        end
    end

    // Next-state logic: field assembly, settle timing and ciphertext shift-out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        k0_d        = k0_q;
        k1_d        = k1_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    cnt_d = 3'd1;
`ifdef KEY_CACHE_EN
                    if (!load_key) begin
                        pt_d[63:56] = in_data;
                        state_d     = S_LOAD_PT;
                    end else begin
                        k0_d[63:56] = in_data;
                        state_d     = S_LOAD_K0;
                    end
`else
                    k0_d[63:56] = in_data;
                    state_d     = S_LOAD_K0;
`endif
                end
            end
            S_LOAD_K0: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    k0_d[byte_lsb +: 8] = in_data;
                    cnt_d               = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_LOAD_K1;
                    end
                end
            end
            S_LOAD_K1: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    k1_d[byte_lsb +: 8] = in_data;
                    cnt_d               = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_LOAD_PT;
                    end
                end
            end
            S_LOAD_PT: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    pt_d[byte_lsb +: 8] = in_data;
                    cnt_d               = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        timer_d = 4'd0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    ct_d    = core_ct;
                    state_d = S_SEND;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            S_SEND: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    ct_d  = {ct_q[55:0], 8'h00};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is forced low while reset is asserted even though the state already reads IDLE.
    assign in_ready  = in_ready_c && rst_n;
    assign out_valid = out_valid_c;
    assign out_data  = out_valid_c ? ct_q[63:56] : 8'h00;
    assign out_last  = out_valid_c && (cnt_q == 3'd7);
    assign busy      = (state_q != S_IDLE);
    assign core_pt   = pt_q;
    assign core_k0   = k0_q;
    assign core_k1   = k1_q;

endmodule
